// File: rtl/ahb_aes_slave_if.sv
// AHB-Lite bus bundle between the CPU master port and the AES register slave.
// Latency: none (wires only).
// Backpressure: carried by HREADYOUT from the slave, returned to all parties as HREADY.
interface ahb_aes_slave_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  HSEL;
    logic [ADDR_WIDTH-1:0] HADDR;
    logic [1:0]            HTRANS;
    logic                  HWRITE;
    logic [2:0]            HSIZE;
    logic [DATA_WIDTH-1:0] HWDATA;
    logic                  HREADY;
    logic [DATA_WIDTH-1:0] HRDATA;
    logic                  HREADYOUT;
    logic                  HRESP;

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        output HRDATA, HREADYOUT, HRESP
    );

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        input  HRDATA, HREADYOUT, HRESP
    );
endinterface

// File: rtl/ahb_aes_slave.sv
// AHB-Lite register block driving an AES-128 core (key/pt/ct, ctrl, status); `AES_IRQ_EN adds CTRL.IE and irq.
// Latency: zero-wait data phase for legal accesses; illegal ones get the two-cycle ERROR response.
// Backpressure: HREADYOUT drops only in the first ERROR cycle; the core itself is never stalled.
module ahb_aes_slave #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                HCLK,
    input  logic                HRESETn,
    ahb_aes_slave_if.slave      bus,
    output logic                aes_start,
    output logic [127:0]        aes_key,
    output logic [127:0]        aes_pt,
    input  logic [127:0]        aes_ct,
    input  logic                aes_done,
    output logic                irq
);
    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_BUSY} state_t;

    typedef struct packed {
        logic       vld;
        logic       wr;
        logic       bad;
        logic       busy;
        logic [3:0] idx;
    } dphase_t;

    localparam logic [3:0] IDX_CTRL = 4'hC;
    localparam logic [3:0] IDX_STAT = 4'hD;

    logic [DATA_WIDTH-1:0] key_q [4];
    logic [DATA_WIDTH-1:0] pt_q  [4];
    logic [DATA_WIDTH-1:0] ct_q  [4];
    state_t                state;
    dphase_t               dp;
    logic                  err2_q;
    logic                  done_q;

`ifdef AES_IRQ_EN
    logic                  ie_q;
    assign irq = done_q & ie_q;
`else
    wire                   ie_q = 1'b0;
    assign irq = 1'b0;
`endif

    wire       accept = bus.HSEL & bus.HREADY & bus.HTRANS[1];
    wire [3:0] a_idx  = bus.HADDR[5:2];
    wire       unused_ok = &{1'b0, bus.HTRANS[0], bus.HADDR[1:0], bus.HADDR[ADDR_WIDTH-1:6]};

    logic err_now, wr_ok, start_hit, busy_now, a_bad;
    logic [DATA_WIDTH-1:0] rdata;

    // START=1 is only known from HWDATA, so that error is resolved in the data phase.
    always_comb begin
        err_now   = dp.vld & (dp.bad | (dp.wr & (dp.idx == IDX_CTRL) & bus.HWDATA[0] & dp.busy));
        wr_ok     = dp.vld & dp.wr & ~err_now;
        start_hit = wr_ok & (dp.idx == IDX_CTRL) & bus.HWDATA[0];
        busy_now  = (state != ST_IDLE) | start_hit;
        a_bad     = (bus.HSIZE != 3'b010)
                  | (bus.HWRITE & (a_idx[3:2] == 2'b10))
                  | (bus.HWRITE & ~a_idx[3] & busy_now);
    end

    always_comb begin
        rdata = '0;
        if (dp.vld & ~dp.wr & ~err_now) begin
            case (dp.idx[3:2])
                2'd0: rdata = key_q[dp.idx[1:0]];
                2'd1: rdata = pt_q[dp.idx[1:0]];
                2'd2: rdata = ct_q[dp.idx[1:0]];
                2'd3: begin
                    if (dp.idx == IDX_CTRL) begin
                        rdata[1] = ie_q;
                    end else if (dp.idx == IDX_STAT) begin
                        rdata[0] = (state != ST_IDLE);
                        rdata[1] = done_q;
                    end
                end
            endcase
        end
    end

    assign bus.HRDATA    = rdata;
    assign bus.HREADYOUT = ~err_now;
    assign bus.HRESP     = err_now | err2_q;
    assign aes_key       = {key_q[0], key_q[1], key_q[2], key_q[3]};
    assign aes_pt        = {pt_q[0], pt_q[1], pt_q[2], pt_q[3]};

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int i = 0; i < 4; i++) begin
                key_q[i] <= '0;
                pt_q[i]  <= '0;
                ct_q[i]  <= '0;
            end
            state     <= ST_IDLE;
            aes_start <= 1'b0;
            dp        <= '0;
            err2_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef AES_IRQ_EN
            ie_q      <= 1'b0;
`endif
        end else begin
            err2_q <= err_now;
            if (err_now) begin
                dp.vld <= 1'b0;
            end else if (bus.HREADY) begin
                dp <= '{vld: accept, wr: bus.HWRITE, bad: a_bad, busy: busy_now, idx: a_idx};
            end

            if (wr_ok) begin
                case (dp.idx[3:2])
                    2'd0: key_q[dp.idx[1:0]] <= bus.HWDATA;
                    2'd1: pt_q[dp.idx[1:0]]  <= bus.HWDATA;
                    2'd3: begin
                        if (dp.idx == IDX_STAT && bus.HWDATA[1]) done_q <= 1'b0;
`ifdef AES_IRQ_EN
                        if (dp.idx == IDX_CTRL) ie_q <= bus.HWDATA[1];
`endif
                    end
                    default: ;
                endcase
            end

            // Placed after the W1C so a same-cycle completion leaves DONE set.
            case (state)
                ST_IDLE: begin
                    if (start_hit) begin
                        state     <= ST_START;
                        aes_start <= 1'b1;
                        done_q    <= 1'b0;
                    end
                end
                ST_START: begin
                    state     <= ST_BUSY;
                    aes_start <= 1'b0;
                end
                ST_BUSY: begin
                    if (aes_done) begin
                        state  <= ST_IDLE;
                        done_q <= 1'b1;
                        for (int i = 0; i < 4; i++)
                            ct_q[i] <= aes_ct[127 - DATA_WIDTH*i -: DATA_WIDTH];
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    aes_start <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ahb_aes_slave.sv
// Directed bench for ahb_aes_slave: register table, FIPS-197 run, ERROR timing, DONE race, reset abort, irq.
module tb_ahb_aes_slave;
    logic HCLK = 1'b0;
    logic HRESETn = 1'b0;
    always #5 HCLK = ~HCLK;

    ahb_aes_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
    assign bus.HREADY = bus.HREADYOUT;

    logic         aes_start, aes_done, irq;
    logic [127:0] aes_key, aes_pt, aes_ct;

    ahb_aes_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .bus       (bus),
        .aes_start (aes_start),
        .aes_key   (aes_key),
        .aes_pt    (aes_pt),
        .aes_ct    (aes_ct),
        .aes_done  (aes_done),
        .irq       (irq)
    );

    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [2:0]   SW = 3'b010;

`ifdef AES_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  size;
        logic        err;
        logic        chk_rd;
        logic [31:0] exp;
    } vec_t;

    vec_t vt [19];
    int   checks = 0;
    int   errors = 0;
    int   start_cnt = 0;
    int   base;

    always @(posedge HCLK) if (aes_start === 1'b1) start_cnt++;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [2:0] size, output logic [31:0] rd,
                        output logic rsp1, output logic rsp, output int waits);
        bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HADDR = addr;
        bus.HWRITE = wr; bus.HSIZE = size;
        @(posedge HCLK); #1;
        bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HWDATA = data;
        waits = 0;
        @(negedge HCLK);
        rsp1 = bus.HRESP;
        while (bus.HREADYOUT !== 1'b1 && waits < 4) begin
            waits++;
            @(negedge HCLK);
        end
        rsp = bus.HRESP;
        rd  = bus.HRDATA;
        @(posedge HCLK); #1;
    endtask

    task automatic wr(input string nm, input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] rd; logic r1, r; int w;
        xfer(1'b1, addr, data, SW, rd, r1, r, w);
        chk({nm, "_okay"}, {w[1:0], r1, r}, 4'b0000);
    endtask

    task automatic wr_err(input string nm, input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] rd; logic r1, r; int w;
        xfer(1'b1, addr, data, SW, rd, r1, r, w);
        chk({nm, "_error"}, {w[1:0], r1, r}, 4'b0111);
    endtask

    task automatic rd_chk(input string nm, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] rd; logic r1, r; int w;
        xfer(1'b0, addr, 32'h0, SW, rd, r1, r, w);
        chk(nm, {w[1:0], r1, r, rd}, {4'b0000, exp});
    endtask

    task automatic core_done(input logic [127:0] ct);
        aes_ct = ct; aes_done = 1'b1;
        @(posedge HCLK); #1;
        aes_done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd; logic r1, r; int w;

        vt[0]  = '{1'b1, 32'h00, 32'h00010203, SW, 1'b0, 1'b0, 32'h0};
        vt[1]  = '{1'b1, 32'h04, 32'h04050607, SW, 1'b0, 1'b0, 32'h0};
        vt[2]  = '{1'b1, 32'h08, 32'h08090a0b, SW, 1'b0, 1'b0, 32'h0};
        vt[3]  = '{1'b1, 32'h0C, 32'h0c0d0e0f, SW, 1'b0, 1'b0, 32'h0};
        vt[4]  = '{1'b1, 32'h10, 32'h00112233, SW, 1'b0, 1'b0, 32'h0};
        vt[5]  = '{1'b1, 32'h14, 32'h44556677, SW, 1'b0, 1'b0, 32'h0};
        vt[6]  = '{1'b1, 32'h18, 32'h8899aabb, SW, 1'b0, 1'b0, 32'h0};
        vt[7]  = '{1'b1, 32'h1C, 32'hccddeeff, SW, 1'b0, 1'b0, 32'h0};
        vt[8]  = '{1'b1, 32'h00, 32'hffffffff, 3'b000, 1'b1, 1'b0, 32'h0};
        vt[9]  = '{1'b1, 32'h20, 32'h12345678, SW, 1'b1, 1'b0, 32'h0};
        vt[10] = '{1'b0, 32'h00, 32'h0, SW, 1'b0, 1'b1, 32'h00010203};
        vt[11] = '{1'b0, 32'h1C, 32'h0, SW, 1'b0, 1'b1, 32'hccddeeff};
        vt[12] = '{1'b0, 32'h20, 32'h0, SW, 1'b0, 1'b1, 32'h00000000};
        vt[13] = '{1'b1, 32'h38, 32'hffffffff, SW, 1'b0, 1'b0, 32'h0};
        vt[14] = '{1'b0, 32'h3C, 32'h0, SW, 1'b0, 1'b1, 32'h00000000};
        vt[15] = '{1'b0, 32'h38, 32'h0, SW, 1'b0, 1'b1, 32'h00000000};
        vt[16] = '{1'b0, 32'h34, 32'h0, SW, 1'b0, 1'b1, 32'h00000000};
        vt[17] = '{1'b0, 32'h30, 32'h0, SW, 1'b0, 1'b1, 32'h00000000};
        vt[18] = '{1'b0, 32'h08, 32'h0, 3'b001, 1'b1, 1'b0, 32'h0};

        bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HADDR = '0; bus.HWRITE = 1'b0;
        bus.HSIZE = SW; bus.HWDATA = '0; aes_done = 1'b0; aes_ct = '0;

        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        chk("rst_bus", {bus.HREADYOUT, bus.HRESP, bus.HRDATA}, {1'b1, 1'b0, 32'h0});
        chk("rst_core", {aes_start, irq, aes_key, aes_pt}, '0);
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        @(posedge HCLK); #1;

        for (int i = 0; i < 19; i++) begin
            xfer(vt[i].wr, vt[i].addr, vt[i].data, vt[i].size, rd, r1, r, w);
            chk($sformatf("vec%0d_resp", i), {w[1:0], r1, r}, vt[i].err ? 4'b0111 : 4'b0000);
            if (vt[i].chk_rd) chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp);
        end
        chk("key_out", aes_key, FIPS_KEY);
        chk("pt_out", aes_pt, FIPS_PT);

        // back-to-back write then read of KEY2 with overlapping phases
        bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HADDR = 32'h08; bus.HWRITE = 1'b1; bus.HSIZE = SW;
        @(posedge HCLK); #1;
        bus.HWDATA = 32'hA5A5A5A5; bus.HWRITE = 1'b0;
        @(negedge HCLK);
        chk("b2b_wr_phase", {bus.HREADYOUT, bus.HRESP}, 2'b10);
        @(posedge HCLK); #1;
        bus.HSEL = 1'b0; bus.HTRANS = 2'b00;
        @(negedge HCLK);
        chk("b2b_rd_phase", {bus.HREADYOUT, bus.HRESP, bus.HRDATA}, {2'b10, 32'hA5A5A5A5});
        @(posedge HCLK); #1;
        wr("key2_restore", 32'h08, 32'h08090a0b);

        // FIPS-197 operation
        base = start_cnt;
        wr("start", 32'h30, 32'h1);
        chk("start_high", aes_start, 1'b1);
        rd_chk("status_busy", 32'h34, 32'h1);
        wr_err("pt0_busy", 32'h10, 32'hDEADBEEF);
        wr_err("start_busy", 32'h30, 32'h1);
        rd_chk("pt0_kept", 32'h10, 32'h00112233);
        chk("start_pulses", start_cnt - base, 1);
        core_done(FIPS_CT);
        rd_chk("status_done", 32'h34, 32'h2);
        rd_chk("ct0", 32'h20, 32'h69c4e0d8);
        rd_chk("ct1", 32'h24, 32'h6a7b0430);
        rd_chk("ct2", 32'h28, 32'hd8cdb780);
        rd_chk("ct3", 32'h2C, 32'h70b4c55a);
        core_done(128'hffffffff_ffffffff_ffffffff_ffffffff);
        rd_chk("done_idle_ignored", 32'h20, 32'h69c4e0d8);

        // DONE W1C racing the completion pulse
        wr("start2", 32'h30, 32'h1);
        rd_chk("status_busy2", 32'h34, 32'h1);
        bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HADDR = 32'h34; bus.HWRITE = 1'b1; bus.HSIZE = SW;
        @(posedge HCLK); #1;
        bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HWDATA = 32'h2;
        aes_ct = FIPS_CT; aes_done = 1'b1;
        @(negedge HCLK);
        chk("w1c_race_phase", {bus.HREADYOUT, bus.HRESP}, 2'b10);
        @(posedge HCLK); #1;
        aes_done = 1'b0;
        rd_chk("status_set_wins", 32'h34, 32'h2);
        wr("w1c", 32'h34, 32'h2);
        rd_chk("status_cleared", 32'h34, 32'h0);

        // interrupt enable
        wr("ctrl_ie", 32'h30, 32'h2);
        rd_chk("ctrl_read", 32'h30, {30'h0, IRQ_ON, 1'b0});
        wr("start_ie", 32'h30, 32'h3);
        chk("irq_idle", irq, 1'b0);
        repeat (3) @(posedge HCLK);
        #1;
        core_done(FIPS_CT);
        #1;
        chk("irq_done", irq, IRQ_ON);
        wr("w1c_irq", 32'h34, 32'h2);
        chk("irq_cleared", irq, 1'b0);

        // reset while busy aborts the operation
        wr("start3", 32'h30, 32'h1);
        rd_chk("status_busy3", 32'h34, 32'h1);
        HRESETn = 1'b0;
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        @(posedge HCLK); #1;
        base = start_cnt;
        core_done(FIPS_CT);
        rd_chk("status_after_rst", 32'h34, 32'h0);
        rd_chk("ct0_after_rst", 32'h20, 32'h0);
        rd_chk("ct3_after_rst", 32'h2C, 32'h0);
        chk("no_start_after_rst", {aes_start, 32'(start_cnt - base)}, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
